// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if
// ID/EX -> EX/MEM bus of the RV64M iterative multiply/divide unit.
//   master: pipeline side. Drives start, flush, funct3_in, rs1_data_in, rs2_data_in
//           and rd_addr_in. Receives stall_out, done_out, result_out and rd_addr_out.
//   slave : unit side, with the opposite directions.
interface ex_muldiv_unit_if #(
  parameter int unsigned REG_WIDTH = 64,
  parameter int unsigned REG_COUNT = 32
);
  localparam int unsigned RdW = $clog2(REG_COUNT);

  logic                 start;
  logic                 flush;
  logic [2:0]           funct3_in;
  logic [REG_WIDTH-1:0] rs1_data_in;
  logic [REG_WIDTH-1:0] rs2_data_in;
  logic [RdW-1:0]       rd_addr_in;
  logic                 stall_out;
  logic                 done_out;
  logic [REG_WIDTH-1:0] result_out;
  logic [RdW-1:0]       rd_addr_out;

  modport master (
    output start, flush, funct3_in, rs1_data_in, rs2_data_in, rd_addr_in,
    input  stall_out, done_out, result_out, rd_addr_out
  );

  modport slave (
    input  start, flush, funct3_in, rs1_data_in, rs2_data_in, rd_addr_in,
    output stall_out, done_out, result_out, rd_addr_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit
// Iterative RV64M multiply/divide unit for the EX stage. One radix-2 step per cycle:
// shift-add multiply and restoring divide share a 2*REG_WIDTH accumulator. The pipeline
// is held with stall_out while the op runs; the result is presented for one cycle
// with done_out. Divide-by-zero and signed overflow bypass the iteration.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : ex_muldiv_unit_if.slave (start/flush/funct3/operands/rd in,
//          stall/done/result/rd out)
module ex_muldiv_unit #(
  parameter int unsigned REG_WIDTH = 64,
  parameter int unsigned REG_COUNT = 32
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);
  localparam int unsigned W    = REG_WIDTH;
  localparam int unsigned RdW  = $clog2(REG_COUNT);
  localparam int unsigned CntW = $clog2(REG_WIDTH);
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e         r_state, w_state_next;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_op;      // multiplicand for multiply, divisor for divide
  logic [W-1:0]   r_result;
  logic [CntW-1:0] r_cnt;
  logic [2:0]     r_funct3;
  logic [RdW-1:0] r_rd;
  logic           r_a_neg, r_b_neg;

  logic           w_accept, w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic           w_div_zero, w_div_ovf, w_fast;
  logic [W-1:0]   w_a_mag, w_b_mag, w_fast_result;
  logic [W:0]     w_mul_sum, w_rem_shift, w_div_diff;
  logic [2*W-1:0] w_mul_step, w_div_step, w_prod_fix;
  logic [W-1:0]   w_quo_fix, w_rem_fix, w_fix_result;

  // ---------------- operand decode at accept ----------------
  assign w_accept   = bus.start && !bus.flush && (r_state == StIdle || r_state == StDone);
  assign w_is_div   = bus.funct3_in[2];
  // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed; DIV/REM both.
  assign w_a_signed = w_is_div ? !bus.funct3_in[0] : (bus.funct3_in[1:0] != 2'b11);
  assign w_b_signed = w_is_div ? !bus.funct3_in[0] : !bus.funct3_in[1];
  assign w_a_neg    = w_a_signed && bus.rs1_data_in[W-1];
  assign w_b_neg    = w_b_signed && bus.rs2_data_in[W-1];
  assign w_a_mag    = w_a_neg ? -bus.rs1_data_in : bus.rs1_data_in;
  assign w_b_mag    = w_b_neg ? -bus.rs2_data_in : bus.rs2_data_in;

  assign w_div_zero = w_is_div && (bus.rs2_data_in == '0);
  assign w_div_ovf  = w_is_div && !bus.funct3_in[0] && (bus.rs1_data_in == MinNeg) &&
                      (bus.rs2_data_in == '1);
  assign w_fast     = w_div_zero || w_div_ovf;

  always_comb begin
    w_fast_result = '0;
    if (w_div_zero) begin
      w_fast_result = bus.funct3_in[1] ? bus.rs1_data_in : '1;
    end else begin
      w_fast_result = bus.funct3_in[1] ? '0 : bus.rs1_data_in;
    end
  end

  // ---------------- iteration step ----------------
  // Multiply: low half holds the multiplier, consumed LSB first; product shifts in from top.
  assign w_mul_sum  = {1'b0, r_acc[2*W-1:W]} + {1'b0, r_op};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};

  // Divide: high half is the partial remainder, low half the dividend turning into quotient.
  // Bit W of the difference is the borrow, since the shifted remainder is below 2*divisor.
  assign w_rem_shift = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_div_diff  = w_rem_shift - {1'b0, r_op};
  assign w_div_step  = !w_div_diff[W] ? {w_div_diff[W-1:0], r_acc[W-2:0], 1'b1}
                                      : {w_rem_shift[W-1:0], r_acc[W-2:0], 1'b0};

  // ---------------- sign fix and result select ----------------
  always_comb begin
    w_prod_fix   = (r_a_neg ^ r_b_neg) ? -r_acc : r_acc;
    w_quo_fix    = r_acc[W-1:0];
    w_rem_fix    = r_acc[2*W-1:W];
    w_fix_result = '0;
    if (r_a_neg ^ r_b_neg) w_quo_fix = -r_acc[W-1:0];
    if (r_a_neg)           w_rem_fix = -r_acc[2*W-1:W];
    if (r_funct3[2]) begin
      w_fix_result = r_funct3[1] ? w_rem_fix : w_quo_fix;
    end else begin
      w_fix_result = (r_funct3[1:0] == 2'b00) ? w_prod_fix[W-1:0] : w_prod_fix[2*W-1:W];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (bus.start) w_state_next = w_fast ? StDone : StCalc;
          else           w_state_next = StIdle;
        end
        StCalc:  if (r_cnt == '0) w_state_next = StFix;
        StFix:   w_state_next = StDone;
        default: w_state_next = StIdle;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.stall_out   = (r_state == StCalc) || (r_state == StFix) || (w_accept && !w_fast);
    bus.done_out    = (r_state == StDone);
    bus.result_out  = r_result;
    bus.rd_addr_out = r_rd;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_rd     <= '0;
      r_a_neg  <= 1'b0;
      r_b_neg  <= 1'b0;
    end else if (w_accept) begin
      r_funct3 <= bus.funct3_in;
      r_rd     <= bus.rd_addr_in;
      r_a_neg  <= w_a_neg;
      r_b_neg  <= w_b_neg;
      r_cnt    <= CntW'(W - 1);
      if (w_fast) r_result <= w_fast_result;
      if (w_is_div) begin
        r_acc <= {{W{1'b0}}, w_a_mag};
        r_op  <= w_b_mag;
      end else begin
        r_acc <= {{W{1'b0}}, w_b_mag};
        r_op  <= w_a_mag;
      end
    end else if (!bus.flush) begin
      if (r_state == StCalc) begin
        r_acc <= r_funct3[2] ? w_div_step : w_mul_step;
        if (r_cnt != '0) r_cnt <= r_cnt - CntW'(1);
      end else if (r_state == StFix) begin
        r_result <= w_fix_result;
      end
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (REG_WIDTH=64, REG_COUNT=32).
// Expected results are queued when an op is issued and compared when done_out pulses.
module tb_ex_muldiv_unit;
  localparam int W   = 64;
  localparam int Lat = W + 2;

  localparam logic [2:0] FMul = 3'b000, FMulh = 3'b001, FMulhsu = 3'b010, FMulhu = 3'b011;
  localparam logic [2:0] FDiv = 3'b100, FDivu = 3'b101, FRem = 3'b110, FRemu = 3'b111;
  localparam logic [63:0] MinNeg = 64'h8000_0000_0000_0000;
  localparam logic [63:0] AllOne = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  ex_muldiv_unit_if #(.REG_WIDTH(64), .REG_COUNT(32)) bus ();

  ex_muldiv_unit #(.REG_WIDTH(64), .REG_COUNT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model built from plain SV arithmetic.
  function automatic logic [63:0] ref_op(input logic [2:0] f3, input logic [63:0] a,
                                         input logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic        [127:0] ua, ub, p;
    ua = {64'd0, a};
    ub = {64'd0, b};
    sa = $signed({{64{a[63]}}, a});
    sb = $signed({{64{b[63]}}, b});
    p  = '0;
    case (f3)
      FMul:    begin p = ua * ub;           return p[63:0];   end
      FMulh:   begin p = sa * sb;           return p[127:64]; end
      FMulhsu: begin p = sa * $signed(ub);  return p[127:64]; end
      FMulhu:  begin p = ua * ub;           return p[127:64]; end
      FDiv: begin
        if (b == 64'd0) return AllOne;
        if (a == MinNeg && b == AllOne) return a;
        return $signed(a) / $signed(b);
      end
      FDivu:   return (b == 64'd0) ? AllOne : a / b;
      FRem: begin
        if (b == 64'd0) return a;
        if (a == MinNeg && b == AllOne) return 64'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 64'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [63:0] a,
                                 input logic [63:0] b);
    if (f3[2] && b == 64'd0) return 1;
    if ((f3 == FDiv || f3 == FRem) && a == MinNeg && b == AllOne) return 1;
    return Lat;
  endfunction

  task automatic to_next;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    bus.start       = 1'b1;
    bus.funct3_in   = f3;
    bus.rs1_data_in = a;
    bus.rs2_data_in = b;
    bus.rd_addr_in  = rd;
  endtask

  // Called in cycle c0 of an accepted op; returns at the start of the cycle after done.
  task automatic await_done(input int c0, input int lat, input string tag);
    int seen   = -1;
    int stalls = 0;
    for (int c = c0; c < 200 && seen < 0; c++) begin
      @(negedge clk);
      if (bus.stall_out === 1'b1) stalls++;
      if (bus.done_out === 1'b1) seen = c;
      to_next();
      bus.start = 1'b0;
    end
    check({tag, "_latency"}, 64'(seen), 64'(lat));
    check({tag, "_stall_cycles"}, 64'(stalls), 64'((lat == 1) ? 0 : lat - c0));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(bus.done_out), 64'd0);
    to_next();
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp, input int lat,
                        input string tag);
    exp_t e;
    e.res = exp;
    e.rd  = rd;
    drive(f3, a, b, rd);
    sb_q.push_back(e);
    await_done(0, lat, tag);
  endtask

  // Scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.done_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("result", bus.result_out, e.res);
        check("rd_addr", 64'(bus.rd_addr_out), 64'(e.rd));
      end
    end
  end

  initial begin
    logic [2:0]  f3;
    logic [63:0] a, b;
    exp_t        e;

    bus.start = 1'b0; bus.flush = 1'b0; bus.funct3_in = '0;
    bus.rs1_data_in = '0; bus.rs2_data_in = '0; bus.rd_addr_in = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stall", 64'(bus.stall_out), 64'd0);
    check("rst_done", 64'(bus.done_out), 64'd0);
    check("rst_result", bus.result_out, 64'd0);
    check("rst_rd", 64'(bus.rd_addr_out), 64'd0);
    to_next();

    // Test-plan directed ops.
    run_op(FMul, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 64'hFFFF_FFFF_FFFF_FFEB, Lat, "mul");
    run_op(FMulhu, AllOne, AllOne, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE, Lat, "mulhu");
    run_op(FMulhsu, AllOne, 64'd2, 5'd7, AllOne, Lat, "mulhsu");
    run_op(FDivu, 64'd5, 64'd0, 5'd8, AllOne, 1, "divu_by0");
    run_op(FRemu, 64'd5, 64'd0, 5'd9, 64'd5, 1, "remu_by0");
    run_op(FDiv, MinNeg, AllOne, 5'd10, MinNeg, 1, "div_ovf");
    run_op(FRem, MinNeg, AllOne, 5'd11, 64'd0, 1, "rem_ovf");
    run_op(FDiv, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd12, 64'hFFFF_FFFF_FFFF_FFFD, Lat, "div_neg");
    run_op(FRem, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd13, 64'd1, Lat, "rem_negdivisor");
    run_op(FMulh, AllOne, AllOne, 5'd14, 64'd0, Lat, "mulh");
    run_op(FRem, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 5'd15, 64'hFFFF_FFFF_FFFF_FFFB, 1, "rem_by0");

    // Back-to-back: REM(-7,2) then DIVU(100,7) with start held in the DONE cycle.
    drive(FRem, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd3);
    e.res = AllOne; e.rd = 5'd3;
    sb_q.push_back(e);
    to_next();
    bus.start = 1'b0;
    repeat (65) @(posedge clk);
    #1;
    drive(FDivu, 64'd100, 64'd7, 5'd9);
    e.res = 64'd14; e.rd = 5'd9;
    sb_q.push_back(e);
    @(negedge clk);
    check("b2b_done1", 64'(bus.done_out), 64'd1);
    check("b2b_stall_accept", 64'(bus.stall_out), 64'd1);
    to_next();
    bus.start = 1'b0;
    @(negedge clk);
    check("b2b_done1_width", 64'(bus.done_out), 64'd0);
    to_next();
    await_done(2, Lat, "b2b_divu");

    // Flush in cycle 10 of a DIV; a new op accepted in cycle 11 completes normally.
    drive(FDiv, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd20);
    to_next();
    bus.start = 1'b0;
    repeat (9) to_next();
    bus.flush = 1'b1;
    to_next();
    bus.flush = 1'b0;
    run_op(FDivu, 64'd100, 64'd7, 5'd4, 64'd14, Lat, "after_flush");

    // Reset in cycle 20 of a DIV.
    drive(FDiv, 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd21);
    to_next();
    bus.start = 1'b0;
    repeat (19) to_next();
    rst = 1'b1;
    to_next();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_stall", 64'(bus.stall_out), 64'd0);
    check("midrst_done", 64'(bus.done_out), 64'd0);
    check("midrst_result", bus.result_out, 64'd0);
    check("midrst_rd", 64'(bus.rd_addr_out), 64'd0);
    to_next();

    // Random ops against the reference model.
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       b = 64'd0;
        1:       b = 64'($signed(32'($urandom_range(0, 200)) - 32'sd100));
        default: b = {$urandom, $urandom};
      endcase
      if (i[0]) a = 64'($signed(32'($urandom_range(0, 2000)) - 32'sd1000));
      run_op(f3, a, b, 5'($urandom_range(0, 31)), ref_op(f3, a, b), ref_lat(f3, a, b),
             "random");
    end

    repeat (3) to_next();
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
